// File: rtl/clk_sel_sequencer.sv
// clk_sel_sequencer: sequences select changes for a three-clock glitch-free switch with settle and dwell timing.
module clk_sel_sequencer #(
    parameter int         SETTLE_CYCLES = 16,
    parameter int         DWELL_CYCLES  = 8,
    parameter logic [1:0] RESET_SEL     = 2'b00,
    parameter int         CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    output logic [1:0] clk_sel,
    output logic [1:0] cur_sel,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [1:0]       RST_SEL   = RESET_SEL[1] ? 2'b10 : RESET_SEL;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYCLES > 0 ? DWELL_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       clk_sel_q, clk_sel_d;
    logic [1:0]       cur_sel_q, cur_sel_d;
    logic             done_q, done_d;
    logic [1:0]       tgt;
    logic             accept;

    assign req_ready = (state_q == IDLE) && !rst;
    assign busy      = state_q != IDLE;
    assign clk_sel   = clk_sel_q;
    assign cur_sel   = cur_sel_q;
    assign done      = done_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clk_sel_d = clk_sel_q;
        cur_sel_d = cur_sel_q;
        done_d    = 1'b0;
        tgt       = req_sel[1] ? 2'b10 : req_sel;
        accept    = req_valid && req_ready;
        case (state_q)
            IDLE: begin
                if (accept && tgt == cur_sel_q) begin
                    done_d = 1'b1;
                end else if (accept) begin
                    clk_sel_d = tgt;
                    cnt_d     = SETTLE_LD;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    done_d    = 1'b1;
                    cur_sel_d = clk_sel_q;
                    cnt_d     = DWELL_LD;
                    state_d   = (DWELL_CYCLES > 0) ? HOLD : IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) state_d = IDLE;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            clk_sel_q <= RST_SEL;
            cur_sel_q <= RST_SEL;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clk_sel_q <= clk_sel_d;
            cur_sel_q <= cur_sel_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_clk_sel_sequencer.sv
// tb_clk_sel_sequencer: scoreboard bench for clk_sel_sequencer (default, RESET_SEL=11 and DWELL_CYCLES=0 instances).
module tb_clk_sel_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    typedef struct {
        logic [1:0] sel;
        int         cyc;
    } exp_t;
    exp_t       sbq[$];
    exp_t       sbq0[$];
    logic [1:0] model_cur;

    logic       rst, req_valid, req_ready, busy, done;
    logic [1:0] req_sel, clk_sel, cur_sel;
    logic       rst_b, valid_b, ready_b, busy_b, done_b;
    logic [1:0] sel_b, clk_sel_b, cur_sel_b;
    logic       rst_c, valid_c, ready_c, busy_c, done_c;
    logic [1:0] sel_c, clk_sel_c, cur_sel_c;

    clk_sel_sequencer u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
        .clk_sel(clk_sel), .cur_sel(cur_sel), .busy(busy), .done(done)
    );
    clk_sel_sequencer #(.RESET_SEL(2'b11)) u_r11 (
        .clk(clk), .rst(rst_b), .req_valid(valid_b), .req_sel(sel_b), .req_ready(ready_b),
        .clk_sel(clk_sel_b), .cur_sel(cur_sel_b), .busy(busy_b), .done(done_b)
    );
    clk_sel_sequencer #(.DWELL_CYCLES(0)) u_d0 (
        .clk(clk), .rst(rst_c), .req_valid(valid_c), .req_sel(sel_c), .req_ready(ready_c),
        .clk_sel(clk_sel_c), .cur_sel(cur_sel_c), .busy(busy_c), .done(done_c)
    );

    function automatic logic [1:0] canon(input logic [1:0] s);
        return (s == 2'b11) ? 2'b10 : s;
    endfunction

    task automatic monitor_main();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected cyc=%0d cur_sel=%b expected no done", cyc, cur_sel);
                end else begin
                    e = sbq.pop_front();
                    if (cur_sel !== e.sel || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL done_main got cyc=%0d cur_sel=%b expected cyc=%0d cur_sel=%b", cyc, cur_sel, e.cyc, e.sel);
                    end
                end
            end
        end
    endtask

    task automatic monitor_d0();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_c === 1'b1) begin
                checks++;
                if (sbq0.size() == 0) begin
                    failures++;
                    $display("FAIL done_d0_unexpected cyc=%0d cur_sel=%b expected no done", cyc, cur_sel_c);
                end else begin
                    e = sbq0.pop_front();
                    if (cur_sel_c !== e.sel || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL done_d0 got cyc=%0d cur_sel=%b expected cyc=%0d cur_sel=%b", cyc, cur_sel_c, e.cyc, e.sel);
                    end
                end
            end
        end
    endtask

    // Drives a request right after a negedge and waits (bounded) for the cycle it is accepted in.
    task automatic request(input logic [1:0] s, output int c);
        int   n;
        exp_t e;
        n = 0;
        req_valid = 1'b1;
        req_sel   = s;
        while (req_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout sel=%b got ready=%b expected 1", s, req_ready);
        end
        c     = cyc;
        e.sel = canon(s);
        e.cyc = (canon(s) == model_cur) ? c + 1 : c + 17;
        sbq.push_back(e);
        model_cur = canon(s);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({clk_sel, cur_sel, busy, done, req_ready} !== 7'b0) begin
            failures++;
            $display("FAIL reset_state got sel=%b cur=%b busy=%b done=%b ready=%b expected all 0", clk_sel, cur_sel, busy, done, req_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || clk_sel !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got ready=%b sel=%b busy=%b expected 1 00 0", req_ready, clk_sel, busy);
        end
    endtask

    task automatic test_reset_sel11();
        checks++;
        if ({clk_sel_b, cur_sel_b, busy_b, done_b, ready_b} !== 7'b1010_000) begin
            failures++;
            $display("FAIL reset11_state got sel=%b cur=%b busy=%b done=%b ready=%b expected 10 10 0 0 0", clk_sel_b, cur_sel_b, busy_b, done_b, ready_b);
        end
        rst_b = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_b !== 1'b1 || clk_sel_b !== 2'b10 || cur_sel_b !== 2'b10) begin
            failures++;
            $display("FAIL reset11_release got ready=%b sel=%b cur=%b expected 1 10 10", ready_b, clk_sel_b, cur_sel_b);
        end
    endtask

    task automatic test_switch();
        int c;
        @(negedge clk);
        request(2'b01, c);
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            checks++;
            if (clk_sel !== 2'b01 || busy !== (k <= 24) || req_ready !== (k >= 25) || done !== (k == 17) ||
                cur_sel !== ((k >= 17) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL switch_k%0d got sel=%b busy=%b ready=%b done=%b cur=%b expected 01 %b %b %b %b", k, clk_sel, busy,
                         req_ready, done, cur_sel, k <= 24, k >= 25, k == 17, (k >= 17) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_same_target();
        int c;
        request(2'b10, c);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (24) @(negedge clk);
        request(2'b11, c);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (clk_sel !== 2'b10 || busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b1 || cur_sel !== 2'b10) begin
            failures++;
            $display("FAIL same_target got sel=%b busy=%b ready=%b done=%b cur=%b expected 10 0 1 1 10", clk_sel, busy, req_ready, done, cur_sel);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL same_target_after got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_hold_toggle();
        int c, c2;
        request(2'b00, c);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            req_sel = (k % 2 == 1) ? 2'b10 : 2'b00;
            if (k < 25) begin
                checks++;
                if (clk_sel !== 2'b00 || req_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL toggle_hold_k%0d got sel=%b ready=%b expected 00 0", k, clk_sel, req_ready);
                end
            end else begin
                request(2'b10, c2);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (clk_sel !== 2'b10 || busy !== 1'b1) begin
            failures++;
            $display("FAIL toggle_accept got sel=%b busy=%b expected 10 1", clk_sel, busy);
        end
        repeat (24) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c;
        request(2'b01, c);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        model_cur = 2'b00;
        #1;
        checks++;
        if (clk_sel !== 2'b00 || cur_sel !== 2'b00 || busy !== 1'b0 || req_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got sel=%b cur=%b busy=%b ready=%b done=%b expected 00 00 0 0 0", clk_sel, cur_sel, busy, req_ready, done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || req_ready !== 1'b1 || clk_sel !== 2'b00 || cur_sel !== 2'b00) begin
                failures++;
                $display("FAIL reset_mid_idle_k%0d got busy=%b ready=%b sel=%b cur=%b expected 0 1 00 00", k, busy, req_ready, clk_sel, cur_sel);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   c;
        exp_t e;
        @(negedge clk);
        rst_c = 1'b0;
        @(negedge clk);
        valid_c = 1'b1;
        sel_c   = 2'b01;
        checks++;
        if (ready_c !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready got %b expected 1", ready_c);
        end
        c     = cyc;
        e.sel = 2'b01;
        e.cyc = c + 17;
        sbq0.push_back(e);
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (k == 1) sel_c = 2'b10;
            if (k == 16) begin
                checks++;
                if (clk_sel_c !== 2'b01 || ready_c !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_settle got sel=%b ready=%b expected 01 0", clk_sel_c, ready_c);
                end
            end
            if (k == 17) begin
                checks++;
                if (ready_c !== 1'b1 || done_c !== 1'b1 || cur_sel_c !== 2'b01) begin
                    failures++;
                    $display("FAIL b2b_first_done got ready=%b done=%b cur=%b expected 1 1 01", ready_c, done_c, cur_sel_c);
                end
                e.sel = 2'b10;
                e.cyc = cyc + 17;
                sbq0.push_back(e);
            end
            if (k == 18) begin
                valid_c = 1'b0;
                checks++;
                if (clk_sel_c !== 2'b10 || busy_c !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_second_accept got sel=%b busy=%b expected 10 1", clk_sel_c, busy_c);
                end
            end
            if (k == 34) begin
                checks++;
                if (done_c !== 1'b1 || cur_sel_c !== 2'b10 || ready_c !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_second_done got done=%b cur=%b ready=%b expected 1 10 1", done_c, cur_sel_c, ready_c);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_sel = 2'b00;
        rst_b = 1'b1;
        valid_b = 1'b0;
        sel_b = 2'b00;
        rst_c = 1'b1;
        valid_c = 1'b0;
        sel_c = 2'b00;
        model_cur = 2'b00;
        fork
            monitor_main();
            monitor_d0();
        join_none
        test_reset();
        test_reset_sel11();
        test_switch();
        test_same_target();
        test_hold_toggle();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0 || sbq0.size() != 0) begin
            failures++;
            $display("FAIL pending_done got main=%0d d0=%0d outstanding expected 0 0", sbq.size(), sbq0.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
